// File: rtl/ifu_if.sv
// Instruction-bus bundle between the fetch unit (master) and instruction memory (slave).
interface ifu_if;
    logic        ibus_req;
    logic        ibus_gnt;
    logic [31:0] ibus_addr;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;

    modport master (
        output ibus_req,
        output ibus_addr,
        input  ibus_gnt,
        input  ibus_rvalid,
        input  ibus_rdata
    );

    modport slave (
        input  ibus_req,
        input  ibus_addr,
        output ibus_gnt,
        output ibus_rvalid,
        output ibus_rdata
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one-outstanding-request fetch FSM with redirect and response discard.
// Optional IFU_MISALIGN_CHECK_EN traps misaligned redirect targets instead of fetching them.
module ifu #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    ifu_if.master       ibus,
    output logic        o_fetch_valid,
    input  logic        i_fetch_ready,
    output logic [31:0] o_fetch_instr,
    output logic [31:0] o_fetch_pc,
`ifdef IFU_MISALIGN_CHECK_EN
    output logic        o_fetch_misaligned,
`endif
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_discard;
    logic        r_req;
    logic        r_fetch_valid;
    logic [31:0] r_fetch_instr;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_redir_pc;
    logic        w_mis;
    logic        w_hold_lock;
    logic        w_outstanding;

`ifdef IFU_MISALIGN_CHECK_EN
    logic r_misaligned;
    assign w_redir_pc         = i_redirect_pc;
    assign w_mis              = |i_redirect_pc[1:0];
    assign w_hold_lock        = r_misaligned;
    assign o_fetch_misaligned = r_misaligned;
`else
    assign w_redir_pc  = i_redirect_pc & 32'hFFFF_FFFC;
    assign w_mis       = 1'b0;
    assign w_hold_lock = 1'b0;
`endif

    // A bus response is still owed to us after this cycle; a redirect must wait it out in WAIT.
    assign w_outstanding = (r_state == S_WAIT && !ibus.ibus_rvalid) ||
                           (r_state == S_REQ  && r_req && ibus.ibus_gnt) ||
                           (r_state == S_HOLD && r_discard && !ibus.ibus_rvalid);

    assign ibus.ibus_req  = r_req;
    assign ibus.ibus_addr = r_pc;
    assign o_fetch_valid  = r_fetch_valid;
    assign o_fetch_instr  = r_fetch_instr;
    assign o_fetch_pc     = r_fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_REQ;
            r_pc          <= BOOT_ADDR;
            r_discard     <= 1'b0;
            r_req         <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_instr <= 32'h0;
            r_fetch_pc    <= 32'h0;
`ifdef IFU_MISALIGN_CHECK_EN
            r_misaligned  <= 1'b0;
`endif
        end else if (i_redirect_valid) begin
            r_pc          <= w_redir_pc;
            r_fetch_valid <= 1'b0;
            r_discard     <= w_outstanding;
            if (w_mis) begin
                // Misaligned target: park in HOLD presenting a trap, never touch the bus.
                r_state       <= S_HOLD;
                r_req         <= 1'b0;
                r_fetch_valid <= 1'b1;
                r_fetch_instr <= 32'h0;
                r_fetch_pc    <= w_redir_pc;
            end else if (w_outstanding) begin
                r_state <= S_WAIT;
                r_req   <= 1'b0;
            end else begin
                r_state <= S_REQ;
                r_req   <= 1'b1;
            end
`ifdef IFU_MISALIGN_CHECK_EN
            r_misaligned <= w_mis;
`endif
        end else begin
            case (r_state)
                S_REQ: begin
                    if (r_req && ibus.ibus_gnt) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b0;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ibus.ibus_rvalid) begin
                        if (r_discard) begin
                            r_discard <= 1'b0;
                            r_state   <= S_REQ;
                            r_req     <= 1'b1;
                        end else begin
                            r_fetch_instr <= ibus.ibus_rdata;
                            r_fetch_pc    <= r_pc;
                            r_pc          <= r_pc + 32'd4;
                            r_fetch_valid <= 1'b1;
                            r_state       <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (ibus.ibus_rvalid) begin
                        r_discard <= 1'b0;
                    end
                    if (i_fetch_ready && !w_hold_lock) begin
                        r_fetch_valid <= 1'b0;
                        r_state       <= S_REQ;
                        r_req         <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end
endmodule
